// File: rtl/control_link_master_if.sv
// Byte-level bundle between the control-link master, the host register bus
// and the 8b/10b encoder/decoder pair.
interface control_link_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [7:0]  tx_byte;
    logic        tx_isK;
    logic [7:0]  rx_byte;
    logic        rx_isK;
    logic        rx_linkOk;

    modport master (
        input  req_valid, req_write, req_addr, req_data,
        input  rx_byte, rx_isK, rx_linkOk,
        output req_ready, rsp_valid, rsp_data, rsp_timeout,
        output tx_byte, tx_isK
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data,
        output rx_byte, rx_isK, rx_linkOk,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout,
        input  tx_byte, tx_isK
    );
endinterface

// File: rtl/control_link_master.sv
// Initiator end of the serial control link: streams 8-byte request frames,
// parses 6-byte response frames and runs the strobe/ack four-phase handshake.
module control_link_master #(
    parameter int TIMEOUT = 4096
) (
    input  logic                         byte_clk,
    input  logic                         reset,
    control_link_master_if.master        bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]      K_COMMA = 8'hBC;

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            cur_write_q, cur_write_d;
    logic [15:0]     cur_addr_q, cur_addr_d;
    logic [31:0]     cur_data_q, cur_data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    logic [2:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_isk_q, tx_isk_d;
    logic            sh_write_q, sh_write_d;
    logic            sh_strobe_q, sh_strobe_d;
    logic [15:0]     sh_addr_q, sh_addr_d;
    logic [31:0]     sh_data_q, sh_data_d;

    logic            rx_active_q, rx_active_d;
    logic [2:0]      rx_cnt_q, rx_cnt_d;
    logic            rx_ack_tmp_q, rx_ack_tmp_d;
    logic [23:0]     rx_dat_tmp_q, rx_dat_tmp_d;
    logic            rx_ack_q, rx_ack_d;
    logic [31:0]     rx_dat_q, rx_dat_d;
    logic            rx_frame_q, rx_frame_d;

    logic            req_ready;
    logic            accept;

    // Ready stays low through the completion cycle so a new request cannot overlap it.
    assign req_ready = !reset && (state_q == ST_IDLE) && bus.rx_linkOk && !rsp_valid_q;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        rx_active_d  = rx_active_q;
        rx_cnt_d     = rx_cnt_q;
        rx_ack_tmp_d = rx_ack_tmp_q;
        rx_dat_tmp_d = rx_dat_tmp_q;
        rx_ack_d     = rx_ack_q;
        rx_dat_d     = rx_dat_q;
        rx_frame_d   = 1'b0;
        if (!bus.rx_linkOk) begin
            rx_active_d = 1'b0;
        end else if (bus.rx_isK) begin
            rx_active_d = (bus.rx_byte == K_COMMA);
            rx_cnt_d    = 3'd1;
        end else if (rx_active_q) begin
            rx_cnt_d = rx_cnt_q + 3'd1;
            case (rx_cnt_q)
                3'd1: rx_ack_tmp_d        = bus.rx_byte[0];
                3'd2: rx_dat_tmp_d[7:0]   = bus.rx_byte;
                3'd3: rx_dat_tmp_d[15:8]  = bus.rx_byte;
                3'd4: rx_dat_tmp_d[23:16] = bus.rx_byte;
                3'd5: begin
                    rx_ack_d    = rx_ack_tmp_q;
                    rx_dat_d    = {bus.rx_byte, rx_dat_tmp_q};
                    rx_frame_d  = 1'b1;
                    rx_active_d = 1'b0;
                end
                default: rx_active_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        cur_write_d   = cur_write_q;
        cur_addr_d    = cur_addr_q;
        cur_data_d    = cur_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_write_d = bus.req_write;
                    cur_addr_d  = bus.req_addr;
                    cur_data_d  = bus.req_data;
                    to_cnt_d    = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ, ST_RELEASE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // Loss of lock or budget expiry aborts even if a frame commits this cycle.
                if (!bus.rx_linkOk || (to_cnt_q == TO_LAST)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                    state_d       = ST_IDLE;
                end else if (rx_frame_q) begin
                    if ((state_q == ST_REQ) && rx_ack_q) begin
                        rsp_data_d = rx_dat_q;
                        state_d    = ST_RELEASE;
                    end else if ((state_q == ST_RELEASE) && !rx_ack_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow is loaded from next-cycle request state so a frame never mixes two requests.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 3'd1;
        sh_write_d  = sh_write_q;
        sh_strobe_d = sh_strobe_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        if (frame_cnt_q == 3'd7) begin
            sh_write_d  = cur_write_d;
            sh_strobe_d = (state_d == ST_REQ);
            sh_addr_d   = cur_addr_d;
            sh_data_d   = cur_data_d;
        end
        tx_isk_d = 1'b0;
        case (frame_cnt_d)
            3'd0: begin
                tx_byte_d = K_COMMA;
                tx_isk_d  = 1'b1;
            end
            3'd1:    tx_byte_d = {6'b0, sh_write_q, sh_strobe_q};
            3'd2:    tx_byte_d = sh_addr_q[7:0];
            3'd3:    tx_byte_d = sh_addr_q[15:8];
            3'd4:    tx_byte_d = sh_data_q[7:0];
            3'd5:    tx_byte_d = sh_data_q[15:8];
            3'd6:    tx_byte_d = sh_data_q[23:16];
            default: tx_byte_d = sh_data_q[31:24];
        endcase
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= '0;
            cur_write_q   <= 1'b0;
            cur_addr_q    <= '0;
            cur_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            frame_cnt_q   <= 3'd0;
            tx_byte_q     <= K_COMMA;
            tx_isk_q      <= 1'b1;
            sh_write_q    <= 1'b0;
            sh_strobe_q   <= 1'b0;
            sh_addr_q     <= '0;
            sh_data_q     <= '0;
            rx_active_q   <= 1'b0;
            rx_cnt_q      <= 3'd0;
            rx_ack_tmp_q  <= 1'b0;
            rx_dat_tmp_q  <= '0;
            rx_ack_q      <= 1'b0;
            rx_dat_q      <= '0;
            rx_frame_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            cur_write_q   <= cur_write_d;
            cur_addr_q    <= cur_addr_d;
            cur_data_q    <= cur_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
            frame_cnt_q   <= frame_cnt_d;
            tx_byte_q     <= tx_byte_d;
            tx_isk_q      <= tx_isk_d;
            sh_write_q    <= sh_write_d;
            sh_strobe_q   <= sh_strobe_d;
            sh_addr_q     <= sh_addr_d;
            sh_data_q     <= sh_data_d;
            rx_active_q   <= rx_active_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_ack_tmp_q  <= rx_ack_tmp_d;
            rx_dat_tmp_q  <= rx_dat_tmp_d;
            rx_ack_q      <= rx_ack_d;
            rx_dat_q      <= rx_dat_d;
            rx_frame_q    <= rx_frame_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.tx_isK      = tx_isk_q;

endmodule

// File: doc/control_link_master.md
# control_link_master

Initiator end of the serial control link. Accepts single register-access requests from the local bus and streams them as repeating 8-byte request frames toward the remote slave. Parses the slave's repeating 6-byte response frames and completes each access with a four-phase strobe/ack handshake carried over the link. Sits between the host register bus and the 8b/10b encode/decode pair, working entirely at byte level in the byte clock domain.

## Interface

- TIMEOUT, 4096: byte_clk cycles allowed for a full transaction (REQ plus RELEASE) before it is aborted.
- byte_clk  in  1  byte clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle and link up; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  register address.
- req_data  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  read data, valid with rsp_valid.
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted.
- tx_byte  out  8  byte to the encoder.
- tx_isK  out  1  tx_byte is a K character.
- rx_byte  in  8  byte from the decoder.
- rx_isK  in  1  rx_byte is a K character.
- rx_linkOk  in  1  decoder lock.

## Operation

- TX frame: 8 bytes, repeated continuously with no gaps. Free-running 3-bit frame counter 0..7, wrapping 7→0.
  - byte0: 0xBC with isK=1.
  - byte1: {6'b0, write, strobe}.
  - byte2/3: addr[7:0], addr[15:8].
  - byte4..7: data, LSB first.
  - All other bytes have isK=0.
- Frame fields {write, strobe, addr, data} are snapshotted into a shadow register on the edge that emits byte0. A frame is never mixed between two requests.
- strobe=1 in state REQ only. In IDLE the frame carries strobe=0, with write/addr/data holding the last request (all zero after reset).
- RX parser:
  - A byte with rx_isK=1 and rx_byte=0xBC starts a frame; byte count is set to 1.
  - Bytes 1..5 are collected as {ack = byte1[0], data = bytes 2..5, LSB first}.
  - On byte 5 the frame is committed: rx_ack and rx_dat are updated, and rx_frame pulses for one cycle.
  - A new comma before byte 5 discards the partial frame and restarts the count.
  - Any other K character, or rx_linkOk=0, discards the partial frame and returns the parser to hunt.
  - Bytes seen while hunting are ignored.
- FSM:
  - IDLE: req_ready = rx_linkOk. On accept, capture the request and go to REQ.
  - REQ: wait for a committed frame with ack=1. Then latch rsp_data ← rx_dat (reads; for writes rsp_data is also loaded, and its value is don't-care) and go to RELEASE.
  - RELEASE: wait for a committed frame with ack=0. Then pulse rsp_valid with rsp_timeout=0 and go to IDLE.
- Committed frames in IDLE are ignored.
- Timeout counter: cleared on accept, counts every cycle in REQ/RELEASE. On reaching TIMEOUT−1, or when rx_linkOk=0 in REQ/RELEASE:
  - pulse rsp_valid with rsp_timeout=1 and rsp_data=0;
  - go to IDLE (frames revert to strobe=0).
- rx_linkOk low and a committed frame in the same cycle: abort wins.

## Timing

- Reset values:
  - tx_byte=0xBC, tx_isK=1, frame counter=0.
  - FSM=IDLE, parser=hunt.
  - rsp_valid=0, rsp_timeout=0, rsp_data=0, shadow register=0.
  - req_ready=0 during reset.
- All outputs are registered except req_ready (combinational from state and rx_linkOk).
- Accept on cycle N: the first strobe=1 byte0 is emitted at the next frame-counter wrap after N. The worst case is 8 cycles later. Accepting in the same cycle the counter is at 7 takes effect in the very next frame.
- A committed response affects FSM state on the cycle after byte 5 is sampled. rsp_valid is asserted the cycle after the committing edge.
- req_ready is 0 from the accept cycle until the cycle after rsp_valid.
- rsp_valid is high for exactly one cycle per accepted request.
- The frame counter runs regardless of link state or reset of the FSM; only reset clears it.

## Test plan

- Reset mid-frame, then release: tx_byte repeats BC(K), 00, 00, 00, 00, 00, 00, 00. rsp_valid=0. req_ready follows rx_linkOk.
- Write 0xDEADBEEF to 0x1234 against a slave model responding ack=1 after 3 frames and ack=0 after 2 more:
  - request frames read BC, 03, 34, 12, EF, BE, AD, DE;
  - then the same frame with byte1=02;
  - single rsp_valid, rsp_timeout=0.
- Read 0x0042, with the model returning ack=1 and data 0xCAFEF00D: byte1=01 during REQ; rsp_data=0xCAFEF00D on rsp_valid.
- No ack ever, TIMEOUT=64: rsp_valid with rsp_timeout=1 and rsp_data=0 exactly 64 cycles after accept. Strobe frames cease.
- Response stream with a comma inserted at byte 3 and a stray K28.7 mid-frame: neither partial frame is committed, and the FSM stays in REQ until a clean ack=1 frame arrives.
- rx_linkOk dropped during RELEASE: immediate timeout completion, req_ready=0 while down. Re-accept succeeds after relock.
